bus6502_responder: RTL and testbench

//  Bus target for the emulated 6502 netlist: the memory/I-O end of the CPU bus.

---
 rtl/bus6502_pkg.sv | 29 ++
 rtl/bus6502_if.sv | 13 +
 rtl/bus6502_ram.sv | 25 ++
 rtl/bus6502_responder.sv | 182 ++++++++++++++++++
 tb/tb_bus6502_responder.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/bus6502_pkg.sv
// Shared types and constants for the 6502 bus responder.
package bus6502_pkg;

  // Bus-phase tracking states
  typedef enum logic [2:0] {
    ALIGN,
    PHI1,
    RD_DATA,
    RD_DRIVE,
    WR_WAIT
  } state_t;

  // Address decode result
  typedef enum logic [1:0] {
    REG_RAM,
    REG_IO,
    REG_VEC,
    REG_NONE
  } region_t;

  // 6502 hardware vector byte addresses
  localparam logic [15:0] VEC_NMI_LO = 16'hFFFA;
  localparam logic [15:0] VEC_NMI_HI = 16'hFFFB;
  localparam logic [15:0] VEC_RST_LO = 16'hFFFC;
  localparam logic [15:0] VEC_RST_HI = 16'hFFFD;
  localparam logic [15:0] VEC_IRQ_LO = 16'hFFFE;
  localparam logic [15:0] VEC_IRQ_HI = 16'hFFFF;

endpackage

// File: rtl/bus6502_if.sv
// CPU bus bundle between the emulated 6502 (master) and the responder (slave).
interface bus6502_if;
  logic [15:0] ab;
  logic        rw;
  logic        sync;
  logic        phi2;
  logic [7:0]  db_i;
  logic [7:0]  db_o;
  logic        db_oe;

  modport master (output ab, rw, sync, phi2, db_i, input db_o, db_oe);
  modport slave  (input ab, rw, sync, phi2, db_i, output db_o, db_oe);
endinterface

// File: rtl/bus6502_ram.sv
// Single-port byte RAM, 2^AW deep, registered (1-cycle) read, read-before-write.
module bus6502_ram #(
  parameter int AW = 11
) (
  input  logic          eclk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rdata_reg;

  // Synchronous write and registered read on the shared address
  always_ff @(posedge eclk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/bus6502_responder.sv
// Memory/I-O target for the emulated 6502 bus: RAM, vector bytes and one I/O port.
// Optional macro BUS6502_STATS_EN adds rd_cnt / wr_cnt / fetch_cnt counters.
module bus6502_responder
  import bus6502_pkg::*;
#(
  parameter int          AW        = 11,
  parameter logic [15:0] IO_ADDR   = 16'hD000,
  parameter logic [15:0] RESET_VEC = 16'h0200,
  parameter logic [15:0] IRQ_VEC   = 16'h0300,
  parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
  input  logic       eclk,
  input  logic       ereset,
  bus6502_if.slave   bus,
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic       io_strobe,
  output logic       late_err
`ifdef BUS6502_STATS_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic [31:0] fetch_cnt
`endif
);

  state_t        state_reg;
  logic          phi2_q_reg;
  logic [15:0]   addr_reg;
  logic [7:0]    db_i_reg;
  logic [7:0]    db_o_reg;
  logic          db_oe_reg;
  logic [7:0]    io_out_reg;
  logic          io_strobe_reg;
  logic          late_err_reg;

  logic          rise;
  logic          fall;
  region_t       region;
  logic [7:0]    vec_byte;
  logic [7:0]    read_mux;
  logic [7:0]    ram_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;

  assign rise = bus.phi2 & ~phi2_q_reg;
  assign fall = ~bus.phi2 & phi2_q_reg;

  // Decode the latched address: vectors win over I/O, I/O over RAM
  always_comb begin
    region = REG_NONE;
    if (addr_reg >= VEC_NMI_LO) begin
      region = REG_VEC;
    end else if (addr_reg == IO_ADDR) begin
      region = REG_IO;
    end else if ((addr_reg >> AW) == 16'd0) begin
      region = REG_RAM;
    end
  end

  // Vector bytes: FFFC/D is reset, NMI and IRQ/BRK share IRQ_VEC
  always_comb begin
    vec_byte = addr_reg[0] ? IRQ_VEC[15:8] : IRQ_VEC[7:0];
    if (addr_reg == VEC_RST_LO) begin
      vec_byte = RESET_VEC[7:0];
    end else if (addr_reg == VEC_RST_HI) begin
      vec_byte = RESET_VEC[15:8];
    end
  end

  // Select read source for the current access
  always_comb begin
    read_mux = OPEN_BUS;
    case (region)
      REG_RAM: read_mux = ram_rdata;
      REG_IO:  read_mux = io_in;
      REG_VEC: read_mux = vec_byte;
      default: read_mux = OPEN_BUS;
    endcase
  end

  // RAM sees the live bus address at phi2 rise, the latched one afterwards
  assign ram_addr = (state_reg == PHI1) ? bus.ab[AW-1:0] : addr_reg[AW-1:0];
  assign ram_we   = (state_reg == WR_WAIT) && fall && (region == REG_RAM) && !ereset;

  bus6502_ram #(.AW(AW)) u_ram (
    .eclk  (eclk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (db_i_reg),
    .rdata (ram_rdata)
  );

  // Bus-phase FSM with registered outputs
  always_ff @(posedge eclk) begin
    phi2_q_reg <= bus.phi2;
    db_i_reg   <= bus.db_i;
    if (ereset) begin
      state_reg     <= ALIGN;
      addr_reg      <= 16'h0000;
      db_o_reg      <= 8'h00;
      db_oe_reg     <= 1'b0;
      io_out_reg    <= 8'h00;
      io_strobe_reg <= 1'b0;
      late_err_reg  <= 1'b0;
    end else begin
      io_strobe_reg <= 1'b0;
      case (state_reg)
        ALIGN: begin
          if (!bus.phi2) state_reg <= PHI1;
        end
        PHI1: begin
          if (rise) begin
            addr_reg  <= bus.ab;
            state_reg <= bus.rw ? RD_DATA : WR_WAIT;
          end
        end
        RD_DATA: begin
          if (fall) begin
            late_err_reg <= 1'b1;
            state_reg    <= PHI1;
          end else begin
            db_o_reg  <= read_mux;
            db_oe_reg <= 1'b1;
            state_reg <= RD_DRIVE;
          end
        end
        RD_DRIVE: begin
          if (fall) begin
            db_oe_reg <= 1'b0;
            state_reg <= PHI1;
          end
        end
        WR_WAIT: begin
          if (fall) begin
            if (region == REG_IO) begin
              io_out_reg    <= db_i_reg;
              io_strobe_reg <= 1'b1;
            end
            state_reg <= PHI1;
          end
        end
        default: state_reg <= ALIGN;
      endcase
    end
  end

  assign bus.db_o  = db_o_reg;
  assign bus.db_oe = db_oe_reg;
  assign io_out    = io_out_reg;
  assign io_strobe = io_strobe_reg;
  assign late_err  = late_err_reg;

`ifdef BUS6502_STATS_EN
  logic        sync_reg;
  logic [31:0] rd_cnt_reg;
  logic [31:0] wr_cnt_reg;
  logic [31:0] fetch_cnt_reg;

  // Access counters, bumped at the phi2 fall that ends each access
  always_ff @(posedge eclk) begin
    if (ereset) begin
      sync_reg      <= 1'b0;
      rd_cnt_reg    <= 32'd0;
      wr_cnt_reg    <= 32'd0;
      fetch_cnt_reg <= 32'd0;
    end else begin
      if (state_reg == PHI1 && rise) sync_reg <= bus.sync;
      if (state_reg == RD_DRIVE && fall) begin
        rd_cnt_reg <= rd_cnt_reg + 32'd1;
        if (sync_reg) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
      if (state_reg == WR_WAIT && fall) wr_cnt_reg <= wr_cnt_reg + 32'd1;
    end
  end

  assign rd_cnt    = rd_cnt_reg;
  assign wr_cnt    = wr_cnt_reg;
  assign fetch_cnt = fetch_cnt_reg;
`endif

endmodule

// File: tb/tb_bus6502_responder.sv
// Scoreboard bench for bus6502_responder: read data and I/O writes are
// predicted by a byte-memory model and compared when the DUT produces them.
module tb_bus6502_responder;

  logic       eclk;
  logic       ereset;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic       io_strobe;
  logic       late_err;
`ifdef BUS6502_STATS_EN
  logic [31:0] rd_cnt, wr_cnt, fetch_cnt;
`endif

  bus6502_if bus ();

  bus6502_responder dut (
    .eclk      (eclk),
    .ereset    (ereset),
    .bus       (bus),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_strobe (io_strobe),
    .late_err  (late_err)
`ifdef BUS6502_STATS_EN
    ,
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .fetch_cnt (fetch_cnt)
`endif
  );

  initial eclk = 1'b0;
  always #5 eclk = ~eclk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [0:2047];
  logic [7:0] sb_q[$];
  logic [7:0] io_q[$];
  logic [7:0] cur_exp = 8'h00;
  logic       oe_prev = 1'b0;
  logic       strobe_prev = 1'b0;
  int         strobe_seen = 0;
  int         strobe_exp = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [15:0] a);
    if (a == 16'hFFFC) return 8'h00;
    if (a == 16'hFFFD) return 8'h02;
    if (a >= 16'hFFFA) return a[0] ? 8'h03 : 8'h00;
    if (a == 16'hD000) return io_in;
    if (a < 16'h0800)  return mem_m[a[10:0]];
    return 8'hFF;
  endfunction

  // Monitor: pop expected read data on db_oe rise, hold-check while driven;
  // check io_out on each strobe and that the strobe lasts one cycle.
  always @(negedge eclk) begin
    if (bus.db_oe && !oe_prev) begin
      if (sb_q.size() == 0) check_val("rd_unexpected", sb_q.size(), 1);
      else cur_exp = sb_q.pop_front();
    end
    if (bus.db_oe) check_val("rd_data", bus.db_o, cur_exp);
    oe_prev = bus.db_oe;
    if (io_strobe) begin
      strobe_seen++;
      check_val("strobe_width", strobe_prev, 0);
      if (io_q.size() == 0) check_val("io_unexpected", io_q.size(), 1);
      else check_val("io_out", io_out, io_q.pop_front());
    end
    strobe_prev = io_strobe;
  end

  task automatic bus_read(input logic [15:0] a, input logic s, input int hi, input bit chg_io);
    logic [7:0] e;
    e = exp_read(a);
    if (hi >= 2) sb_q.push_back(e);
    $display("rd addr=%04h sync=%0d hi=%0d exp=%02h", a, s, hi, e);
    bus.ab = a; bus.rw = 1'b1; bus.sync = s; bus.phi2 = 1'b1;
    for (int j = 1; j <= hi; j++) begin
      @(negedge eclk);
      check_val("rd_oe_high", bus.db_oe, (j >= 2));
      if (chg_io && j == 2) io_in = ~io_in;
    end
    bus.phi2 = 1'b0; bus.sync = 1'b0;
    @(negedge eclk);
    check_val("rd_oe_fall", bus.db_oe, 0);
    @(negedge eclk);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hi);
    $display("wr addr=%04h data=%02h", a, d);
    if (a >= 16'hFFFA) begin
    end else if (a == 16'hD000) begin
      io_q.push_back(d);
      strobe_exp++;
    end else if (a < 16'h0800) begin
      mem_m[a[10:0]] = d;
    end
    bus.ab = a; bus.rw = 1'b0; bus.sync = 1'b0; bus.db_i = d; bus.phi2 = 1'b1;
    repeat (hi) @(negedge eclk);
    bus.phi2 = 1'b0; bus.db_i = ~d;
    repeat (2) @(negedge eclk);
    check_val("wr_oe", bus.db_oe, 0);
  endtask

  task automatic do_reset();
    $display("reset");
    ereset = 1'b1; bus.phi2 = 1'b0;
    repeat (3) @(negedge eclk);
    check_val("rst_db_oe", bus.db_oe, 0);
    check_val("rst_db_o", bus.db_o, 0);
    check_val("rst_io_out", io_out, 0);
    check_val("rst_late_err", late_err, 0);
    ereset = 1'b0;
    @(negedge eclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    ereset = 1'b1; io_in = 8'h3C;
    bus.ab = 16'hD000; bus.rw = 1'b0; bus.sync = 1'b0; bus.phi2 = 1'b0; bus.db_i = 8'h99;
    repeat (3) @(negedge eclk);
    check_val("rst_db_oe", bus.db_oe, 0);
    check_val("rst_db_o", bus.db_o, 0);
    check_val("rst_io_out", io_out, 0);
    check_val("rst_strobe", io_strobe, 0);
    check_val("rst_late_err", late_err, 0);
    // phi2 high at release: the edge must be ignored while aligning
    $display("release with phi2 high");
    ereset = 1'b0; bus.phi2 = 1'b1;
    repeat (3) begin @(negedge eclk); check_val("align_oe", bus.db_oe, 0); end
    bus.phi2 = 1'b0;
    repeat (3) begin @(negedge eclk); check_val("align_oe", bus.db_oe, 0); end
    check_val("align_io_out", io_out, 0);
    check_val("align_strobes", strobe_seen, 0);

    bus_write(16'h0123, 8'h5A, 3);
    bus_read(16'h0123, 1'b0, 3, 1'b0);
    bus_read(16'hFFFC, 1'b0, 3, 1'b0);
    bus_read(16'hFFFD, 1'b0, 3, 1'b0);
    bus_write(16'hFFFC, 8'h77, 3);
    bus_read(16'hFFFC, 1'b0, 3, 1'b0);
    bus_read(16'hFFFA, 1'b0, 3, 1'b0);
    bus_read(16'hFFFF, 1'b0, 3, 1'b0);
    bus_write(16'hD000, 8'hA5, 3);
    bus_read(16'hD000, 1'b0, 4, 1'b1);
    bus_write(16'h0000, 8'h10, 3);
    bus_write(16'h0800, 8'h99, 3);
    bus_read(16'h0000, 1'b0, 3, 1'b0);
    bus_read(16'h0800, 1'b0, 3, 1'b0);
    bus_write(16'h07FF, 8'hC3, 4);
    bus_read(16'h07FF, 1'b0, 3, 1'b0);
    bus_read(16'h4000, 1'b0, 3, 1'b0);
    bus_read(16'h0123, 1'b1, 5, 1'b0);

    // phi2 too short: late_err, no drive
    bus_read(16'h0123, 1'b0, 1, 1'b0);
    check_val("late_err_set", late_err, 1);
    bus_read(16'h0123, 1'b0, 3, 1'b0);
    check_val("late_err_sticky", late_err, 1);
    do_reset();

    // Reset in the middle of a write: nothing committed
    bus_write(16'h0050, 8'h22, 3);
    $display("abort wr addr=0050 data=11");
    bus.ab = 16'h0050; bus.rw = 1'b0; bus.db_i = 8'h11; bus.phi2 = 1'b1;
    repeat (2) @(negedge eclk);
    ereset = 1'b1;
    @(negedge eclk);
    bus.phi2 = 1'b0;
    repeat (2) @(negedge eclk);
    ereset = 1'b0;
    @(negedge eclk);
    bus_read(16'h0050, 1'b0, 3, 1'b0);

    // Reset in the middle of a read: db_oe drops at the next edge
    $display("abort rd addr=0123");
    sb_q.push_back(exp_read(16'h0123));
    bus.ab = 16'h0123; bus.rw = 1'b1; bus.phi2 = 1'b1;
    repeat (2) @(negedge eclk);
    check_val("abort_oe_on", bus.db_oe, 1);
    ereset = 1'b1;
    @(negedge eclk);
    check_val("abort_oe_off", bus.db_oe, 0);
    bus.phi2 = 1'b0;
    @(negedge eclk);
    ereset = 1'b0;
    @(negedge eclk);

    do_reset();
    bus_read(16'h0123, 1'b1, 3, 1'b0);
    bus_read(16'h0123, 1'b0, 3, 1'b0);
    bus_read(16'hFFFC, 1'b0, 3, 1'b0);
    bus_write(16'h0124, 8'h01, 3);
`ifdef BUS6502_STATS_EN
    check_val("rd_cnt", rd_cnt, 3);
    check_val("fetch_cnt", fetch_cnt, 1);
    check_val("wr_cnt", wr_cnt, 1);
`endif

    repeat (2) @(negedge eclk);
    check_val("sb_drain", sb_q.size(), 0);
    check_val("io_drain", io_q.size(), 0);
    check_val("strobe_count", strobe_seen, strobe_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
